// File: rtl/ula_pkg.sv
// Shared definitions for the ALU issue/writeback stage: ALU control codes,
// R-type funct values and field offsets, FSM states and the funct decoder.
// Pure declarations; no logic, no latency, no backpressure.
package ula_pkg;

    // Register file geometry: 5-bit register fields address 32 registers.
    localparam int REG_AW = 5;

    // ALU control codes, as understood by the ALU's inputULA port.
    localparam logic [3:0] ULA_AND = 4'b0000;
    localparam logic [3:0] ULA_OR  = 4'b0001;
    localparam logic [3:0] ULA_ADD = 4'b0010;
    localparam logic [3:0] ULA_SUB = 4'b0110;
    localparam logic [3:0] ULA_SLT = 4'b0111;
    // Idle code: falls into the ALU's default case, which yields 0.
    localparam logic [3:0] ULA_NOP = 4'b1111;

    // Supported R-type funct values.
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    // R-type field LSB positions: op(6) rs(5) rt(5) rd(5) shamt(5) funct(6).
    localparam int OP_LSB    = 26;
    localparam int RS_LSB    = 21;
    localparam int RT_LSB    = 16;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_LSB = 6;
    localparam int FUNCT_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WB    = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    typedef struct packed {
        logic       legal;
        logic [3:0] ctrl;
    } dec_t;

    // Map op/funct onto an ALU control code. Anything other than op=0 with one
    // of the five known funct values is illegal and reports ULA_NOP.
    function automatic dec_t ula_decode(input logic [5:0] op,
                                        input logic [5:0] funct);
        dec_t d;
        d.legal = 1'b1;
        d.ctrl  = ULA_NOP;
        case (funct)
            FUNCT_AND: d.ctrl = ULA_AND;
            FUNCT_OR:  d.ctrl = ULA_OR;
            FUNCT_ADD: d.ctrl = ULA_ADD;
            FUNCT_SUB: d.ctrl = ULA_SUB;
            FUNCT_SLT: d.ctrl = ULA_SLT;
            default:   d.legal = 1'b0;
        endcase
        if (op != 6'd0) begin
            d.legal = 1'b0;
        end
        if (!d.legal) begin
            d.ctrl = ULA_NOP;
        end
        return d;
    endfunction

endpackage

// File: rtl/ula_regfile.sv
// Architectural register file, NREGS x XLEN, register 0 reads as zero.
// Latency: reads are combinational, the single write lands at the clock edge.
// Backpressure: none; a write is taken whenever we is high (index 0 dropped).
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (clears all regs)
//   ra_addr/ra_data   operand A read port (combinational)
//   rb_addr/rb_data   operand B read port (combinational)
//   dbg_addr/dbg_data debug read port (combinational)
//   we/wa/wd          synchronous write port
module ula_regfile
    import ula_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int XLEN  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] ra_addr,
    output logic [XLEN-1:0]   ra_data,
    input  logic [REG_AW-1:0] rb_addr,
    output logic [XLEN-1:0]   rb_data,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [XLEN-1:0]   dbg_data,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [XLEN-1:0]   wd
);

    logic [XLEN-1:0] mem [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            mem[wa] <= wd;
        end
    end

    // R0 is forced to zero on every read port rather than relying on the
    // storage never being written.
    always_comb begin
        ra_data  = (ra_addr  == '0) ? '0 : mem[ra_addr];
        rb_data  = (rb_addr  == '0) ? '0 : mem[rb_addr];
        dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];
    end

endmodule

// File: rtl/ula_issue.sv
// Issue/writeback stage around the ALU: decode, operand read, result writeback.
// Latency: accept at T, operands to ALU during T+1, writeback (done) at T+2.
// Backpressure: instr_ready only in IDLE, so one instruction per 3 cycles.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   instr_valid/instr_ready    instruction handshake; instr is the R-type word
//   ld_en/ld_addr/ld_data      register preload, honoured only in IDLE
//   ula_ctrl/ula_a/ula_b       control code and operands to the ALU
//   ula_result                 ALU result, one cycle after the operands
//   done/wb_addr/wb_data       writeback pulse with its destination and value
//   err                        pulse for an accepted unsupported instruction
//   dbg_addr/dbg_data          combinational register file peek
module ula_issue
    import ula_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int XLEN  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    input  logic              ld_en,
    input  logic [REG_AW-1:0] ld_addr,
    input  logic [XLEN-1:0]   ld_data,
    output logic [3:0]        ula_ctrl,
    output logic [XLEN-1:0]   ula_a,
    output logic [XLEN-1:0]   ula_b,
    input  logic [XLEN-1:0]   ula_result,
    output logic              done,
    output logic [REG_AW-1:0] wb_addr,
    output logic [XLEN-1:0]   wb_data,
    output logic              err,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [XLEN-1:0]   dbg_data
);

    state_t state, state_nxt;

    // Low throughout reset and for the first cycle after release, so the
    // producer cannot hand over an instruction until the block is running.
    logic alive;

    logic              accept;
    dec_t              dec;
    logic [REG_AW-1:0] rs, rt, rd;
    logic [REG_AW-1:0] rd_q;
    logic [XLEN-1:0]   rs_data, rt_data;

    logic              rf_we;
    logic [REG_AW-1:0] rf_wa;
    logic [XLEN-1:0]   rf_wd;

    // shamt has no meaning for the supported operations.
    logic unused_shamt;
    assign unused_shamt = ^instr[SHAMT_LSB +: 5];

    assign rs  = instr[RS_LSB +: REG_AW];
    assign rt  = instr[RT_LSB +: REG_AW];
    assign rd  = instr[RD_LSB +: REG_AW];
    assign dec = ula_decode(instr[OP_LSB +: 6], instr[FUNCT_LSB +: 6]);

    assign accept = instr_valid & instr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive <= 1'b0;
        end else begin
            alive <= 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        wb_addr     = '0;
        wb_data     = '0;
        case (state)
            ST_IDLE: begin
                instr_ready = alive;
                if (accept) begin
                    state_nxt = dec.legal ? ST_ISSUE : ST_ERR;
                end
            end
            ST_ISSUE: begin
                state_nxt = ST_WB;
            end
            ST_WB: begin
                // ALU sampled the operands at the end of ISSUE, so its
                // registered result is on ula_result now.
                done      = 1'b1;
                wb_addr   = rd_q;
                wb_data   = ula_result;
                state_nxt = ST_IDLE;
            end
            ST_ERR: begin
                err       = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // ALU-facing registers: loaded at the accept edge, valid through ISSUE.
    // Operands are read before any same-cycle preload lands in the file.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ula_ctrl <= ULA_NOP;
            ula_a    <= '0;
            ula_b    <= '0;
            rd_q     <= '0;
        end else if (accept && dec.legal) begin
            ula_ctrl <= dec.ctrl;
            ula_a    <= rs_data;
            ula_b    <= rt_data;
            rd_q     <= rd;
        end else if (state == ST_ISSUE) begin
            ula_ctrl <= ULA_NOP;
        end
    end

    // ---------------------------------------------------------------------
    // Register file write port: writeback in WB, preload in IDLE. The two
    // never coincide because they belong to different states.
    // ---------------------------------------------------------------------
    always_comb begin
        rf_we = 1'b0;
        rf_wa = ld_addr;
        rf_wd = ld_data;
        if (state == ST_WB) begin
            rf_we = 1'b1;
            rf_wa = rd_q;
            rf_wd = ula_result;
        end else if ((state == ST_IDLE) && ld_en) begin
            rf_we = 1'b1;
        end
    end

    ula_regfile #(
        .NREGS (NREGS),
        .XLEN  (XLEN)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra_addr  (rs),
        .ra_data  (rs_data),
        .rb_addr  (rt),
        .rb_data  (rt_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .we       (rf_we),
        .wa       (rf_wa),
        .wd       (rf_wd)
    );

endmodule

// File: tb/tb_ula_issue.sv
// Directed bench for ula_issue with a behavioural ALU (one-cycle registered
// result) attached; all expected values are hand-computed constants.
module tb_ula_issue;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        ld_en;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic [3:0]  ula_ctrl;
    logic [31:0] ula_a;
    logic [31:0] ula_b;
    logic [31:0] ula_result;
    logic        done;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        err;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int checks = 0;
    int errors = 0;

    ula_issue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .ula_ctrl    (ula_ctrl),
        .ula_a       (ula_a),
        .ula_b       (ula_b),
        .ula_result  (ula_result),
        .done        (done),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .err         (err),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: registered result, unsigned slt, default yields 0.
    always_ff @(posedge clk) begin
        case (ula_ctrl)
            4'b0000: ula_result <= ula_a & ula_b;
            4'b0001: ula_result <= ula_a | ula_b;
            4'b0010: ula_result <= ula_a + ula_b;
            4'b0110: ula_result <= ula_a - ula_b;
            4'b0111: ula_result <= (ula_a < ula_b) ? 32'd1 : 32'd0;
            default: ula_result <= 32'd0;
        endcase
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {6'd0, rs, rt, rd, 5'd0, funct};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    task automatic dbg(input string tag, input logic [4:0] a, input logic [31:0] exp);
        dbg_addr = a;
        #1;
        chk(tag, dbg_data, exp);
    endtask

    // Called at a negedge in IDLE. Walks accept -> ISSUE -> WB -> IDLE.
    task automatic run_op(input string tag, input logic [31:0] w, input logic [3:0] ectrl,
                          input logic [31:0] ea, input logic [31:0] eb,
                          input logic [4:0] erd, input logic [31:0] ewb);
        chk({tag, "_rdy_idle"}, {31'd0, instr_ready}, 32'd1);
        instr_valid = 1'b1;
        instr       = w;
        @(negedge clk);
        instr_valid = 1'b0;
        instr       = 32'hFFFF_FFFF;
        chk({tag, "_ctrl"}, {28'd0, ula_ctrl}, {28'd0, ectrl});
        chk({tag, "_a"}, ula_a, ea);
        chk({tag, "_b"}, ula_b, eb);
        chk({tag, "_rdy_issue"}, {31'd0, instr_ready}, 32'd0);
        chk({tag, "_done_issue"}, {31'd0, done}, 32'd0);
        @(negedge clk);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_wb_addr"}, {27'd0, wb_addr}, {27'd0, erd});
        chk({tag, "_wb_data"}, wb_data, ewb);
        chk({tag, "_rdy_wb"}, {31'd0, instr_ready}, 32'd0);
        chk({tag, "_ctrl_wb"}, {28'd0, ula_ctrl}, 32'hF);
        @(negedge clk);
        chk({tag, "_done_after"}, {31'd0, done}, 32'd0);
        chk({tag, "_rdy_back"}, {31'd0, instr_ready}, 32'd1);
    endtask

    task automatic run_bad(input string tag, input logic [31:0] w);
        instr_valid = 1'b1;
        instr       = w;
        @(negedge clk);
        instr_valid = 1'b0;
        instr       = 32'd0;
        chk({tag, "_err"}, {31'd0, err}, 32'd1);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_ctrl"}, {28'd0, ula_ctrl}, 32'hF);
        chk({tag, "_rdy"}, {31'd0, instr_ready}, 32'd0);
        @(negedge clk);
        chk({tag, "_err_after"}, {31'd0, err}, 32'd0);
        chk({tag, "_done_after"}, {31'd0, done}, 32'd0);
        chk({tag, "_ctrl_after"}, {28'd0, ula_ctrl}, 32'hF);
        chk({tag, "_rdy_back"}, {31'd0, instr_ready}, 32'd1);
    endtask

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = 32'd0;
        ld_en       = 1'b0;
        ld_addr     = 5'd0;
        ld_data     = 32'd0;
        dbg_addr    = 5'd0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ctrl", {28'd0, ula_ctrl}, 32'hF);
        chk("rst_a", ula_a, 32'd0);
        chk("rst_b", ula_b, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_wb_addr", {27'd0, wb_addr}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_rdy", {31'd0, instr_ready}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_rdy_low", {31'd0, instr_ready}, 32'd0);
        @(negedge clk);
        chk("rel_rdy_high", {31'd0, instr_ready}, 32'd1);

        preload(5'd1, 32'd5);
        preload(5'd2, 32'd3);
        dbg("dbg_r1", 5'd1, 32'd5);
        dbg("dbg_r2", 5'd2, 32'd3);

        // add R3 = R1 + R2
        chk("add_word", rtype(5'd1, 5'd2, 5'd3, 6'h20), 32'h0022_1820);
        run_op("add", 32'h0022_1820, 4'b0010, 32'd5, 32'd3, 5'd3, 32'd8);
        dbg("dbg_r3", 5'd3, 32'd8);

        // sub R4 = R2 - R1 wraps
        run_op("sub", rtype(5'd2, 5'd1, 5'd4, 6'h22), 4'b0110, 32'd3, 32'd5, 5'd4, 32'hFFFF_FFFE);
        dbg("dbg_r4", 5'd4, 32'hFFFF_FFFE);

        // slt R5 = R2 < R1
        run_op("slt", rtype(5'd2, 5'd1, 5'd5, 6'h2A), 4'b0111, 32'd3, 32'd5, 5'd5, 32'd1);
        dbg("dbg_r5", 5'd5, 32'd1);

        // Dependent chain back to back
        run_op("or", rtype(5'd1, 5'd2, 5'd6, 6'h25), 4'b0001, 32'd5, 32'd3, 5'd6, 32'd7);
        run_op("and", rtype(5'd6, 5'd2, 5'd7, 6'h24), 4'b0000, 32'd7, 32'd3, 5'd7, 32'd3);
        dbg("dbg_r6", 5'd6, 32'd7);
        dbg("dbg_r7", 5'd7, 32'd3);

        // Illegal funct, destination R3 must stay 8
        run_bad("bad_funct", rtype(5'd1, 5'd2, 5'd3, 6'h00));
        dbg("bad_funct_r3", 5'd3, 32'd8);
        // Illegal op
        run_bad("bad_op", {6'h08, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20});
        dbg("bad_op_r3", 5'd3, 32'd8);

        // Write to R0 is discarded; preload to R0 ignored
        run_op("add_r0", rtype(5'd1, 5'd2, 5'd0, 6'h20), 4'b0010, 32'd5, 32'd3, 5'd0, 32'd8);
        dbg("dbg_r0_wb", 5'd0, 32'd0);
        preload(5'd0, 32'hDEAD_BEEF);
        dbg("dbg_r0_ld", 5'd0, 32'd0);

        // Preload coinciding with accept: operand sees old R1, load still lands.
        // Preload during ISSUE is ignored.
        instr_valid = 1'b1;
        instr       = rtype(5'd1, 5'd2, 5'd9, 6'h20);
        ld_en       = 1'b1;
        ld_addr     = 5'd1;
        ld_data     = 32'd9;
        @(negedge clk);
        instr_valid = 1'b0;
        ld_addr     = 5'd2;
        ld_data     = 32'h77;
        chk("rbw_a", ula_a, 32'd5);
        chk("rbw_b", ula_b, 32'd3);
        @(negedge clk);
        ld_en = 1'b0;
        chk("rbw_wb_data", wb_data, 32'd8);
        chk("rbw_done", {31'd0, done}, 32'd1);
        @(negedge clk);
        dbg("rbw_r1", 5'd1, 32'd9);
        dbg("ld_issue_r2", 5'd2, 32'd3);
        dbg("rbw_r9", 5'd9, 32'd8);

        // Reset during ISSUE of add to R3 (R3 currently 8)
        instr_valid = 1'b1;
        instr       = rtype(5'd1, 5'd2, 5'd3, 6'h20);
        @(negedge clk);
        instr_valid = 1'b0;
        chk("mid_ctrl_pre", {28'd0, ula_ctrl}, 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_ctrl", {28'd0, ula_ctrl}, 32'hF);
        chk("mid_a", ula_a, 32'd0);
        chk("mid_b", ula_b, 32'd0);
        chk("mid_done", {31'd0, done}, 32'd0);
        chk("mid_err", {31'd0, err}, 32'd0);
        chk("mid_rdy", {31'd0, instr_ready}, 32'd0);
        chk("mid_wb_data", wb_data, 32'd0);
        dbg("mid_r3", 5'd3, 32'd0);
        @(negedge clk);
        chk("mid_done2", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("mid_rdy_rel", {31'd0, instr_ready}, 32'd0);
        @(negedge clk);
        chk("mid_rdy_back", {31'd0, instr_ready}, 32'd1);
        chk("mid_done3", {31'd0, done}, 32'd0);
        dbg("mid_r3_after", 5'd3, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ula_issue.md
Name: ula_issue

Overview:
- Multicycle issue/writeback stage that sits directly upstream and downstream of the ALU (ULA).
- Accepts one R-type instruction per handshake and decodes `funct` into the 4-bit ALU control code.
- Reads both operands from an internal register file and drives them to the ALU.
- Captures the ALU's registered result one cycle later and writes it back to `rd`.

Parameters:
- NREGS, 32, number of architectural registers; fixed at 32 because register fields are 5 bits. Register 0 is hardwired to zero.
- XLEN, 32, operand width; must match the ALU's 32-bit operands.

Ports:
- clk  in  1  single clock; every flop is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  an instruction is offered on `instr`.
- instr_ready  out  1  the block can accept an instruction; high only in IDLE.
- instr  in  32  R-type word, MSB first: op(6) rs(5) rt(5) rd(5) shamt(5) funct(6).
- ld_en  in  1  register preload strobe (bench/boot use).
- ld_addr  in  5  preload register index.
- ld_data  in  32  preload value.
- ula_ctrl  out  4  to ALU `inputULA`.
- ula_a  out  32  to ALU operand `a`.
- ula_b  out  32  to ALU operand `b`.
- ula_result  in  32  from ALU `outputULA`; registered inside the ALU with 1-cycle latency.
- done  out  1  one-cycle pulse; writeback is occurring this cycle.
- wb_addr  out  5  destination register; valid while `done` is high.
- wb_data  out  32  writeback value; valid while `done` is high.
- err  out  1  one-cycle pulse; an unsupported instruction was accepted.
- dbg_addr  in  5  combinational debug read address.
- dbg_data  out  32  register file contents at `dbg_addr`; always 0 when `dbg_addr` is 0.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE.
  - All registers clear to 0.
  - ula_ctrl=4'b1111; the ALU default case then yields 0.
  - ula_a=0, ula_b=0, done=0, err=0, wb_addr=0, wb_data=0, instr_ready=0.
  - instr_ready rises in the first cycle after reset release.
  - Reset mid-operation drops the in-flight instruction with no writeback.
- FSM states: IDLE, ISSUE, WB, ERR.
- Handshake: accept occurs on a rising edge with instr_valid & instr_ready. `instr` must be stable only in that cycle.
- Decode (requires op=0):
  - funct 0x24 -> 0000 (AND)
  - funct 0x25 -> 0001 (OR)
  - funct 0x20 -> 0010 (add)
  - funct 0x22 -> 0110 (sub)
  - funct 0x2A -> 0111 (slt)
  - shamt is ignored.
- Legal instruction:
  - At the accept edge T: latch ula_ctrl, ula_a=R[rs], ula_b=R[rt] and rd; go to ISSUE.
  - ISSUE (cycle T+1): outputs are valid; the ALU samples them at the end of the cycle. Then ula_ctrl returns to 1111 and the state goes to WB.
  - WB (cycle T+2): done=1, wb_addr=rd, wb_data=ula_result. R[rd] is written at the end of WB; a write to rd=0 is discarded. Then the state goes to IDLE.
- Illegal instruction (op≠0 or unknown funct): accept → ERR for one cycle with err=1, no ALU issue, no write → IDLE.
- Throughput: one instruction per 3 cycles. A dependent instruction reads the updated value because the write completes before the next accept.
- Arithmetic is modulo 2^32, performed by the ALU. slt is the ALU's unsigned compare; this block does no arithmetic.
- Preload:
  - ld_en is honoured only in IDLE and ignored in all other states.
  - ld_en with ld_addr=0 is ignored.
  - If ld_en and accept occur in the same cycle, operands read the pre-load value (read-before-write), and the load still takes effect.
- instr_valid outside IDLE is ignored; the producer holds it.

Decomposition:
- Shared package ula_pkg holds:
  - ALU control codes: ULA_AND, ULA_OR, ULA_ADD, ULA_SUB, ULA_SLT, ULA_NOP=4'b1111.
  - funct constants.
  - R-type field offsets.
  - FSM state enum.
- One sub-module: ula_regfile (32x32, two async read ports plus debug read, one sync write port, async reset, R0 hardwired to 0).
- Decode is a function in the package.

Test Plan:
- Preload R1=5, R2=3; issue add rd=3 rs=1 rt=2 (0x00221820):
  - ISSUE cycle: ula_ctrl=0010, a=5, b=3.
  - WB cycle: done=1, wb_addr=3, wb_data=8.
  - Afterwards dbg R3=8.
- With R1=5, R2=3: sub R4=R2-R1 → R4=0xFFFFFFFE.
- With R1=5, R2=3: slt R5=R2<R1 → R5=1.
- Dependent chain:
  - First: or R6=R1|R2 → R6=7.
  - Immediately after: and R7=R6&R2 → R7=3 (uses the new R6).
  - Verify instr_ready is low for exactly 2 cycles after each accept.
- Illegal funct 0x00, and separately op=0x08:
  - err pulses 1 cycle, done stays 0, no register changes.
  - ula_ctrl stays 1111.
- Write to rd=0 gives dbg R0=0. Asserting rst_n=0 during ISSUE of an add to R3:
  - All outputs go to their reset values asynchronously, R3=0, no done pulse.
  - instr_ready=1 one cycle after release.
